// File: rtl/round_sequencer.sv
// Round sequencer for an iterative block cipher: IDLE -> LOAD -> ROUNDS x RUN -> HOLD, Moore-decoded controls.
// Build option SEQ_ABORT_EN adds an ABORT input that cancels an in-flight block without a DONE pulse.
module round_sequencer #(
    parameter int ROUNDS = 32,
    parameter int IDX_W  = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             MODE,
    input  logic             OUT_READY,
`ifdef SEQ_ABORT_EN
    input  logic             ABORT,
`endif
    output logic             LOAD,
    output logic             ROUND_EN,
    output logic [IDX_W-1:0] ROUND_IDX,
    output logic             BUSY,
    output logic             OUT_VALID,
    output logic             DONE
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             start_q;
    logic             abort_w;
    logic             start_acc;
    logic             run_last;

`ifdef SEQ_ABORT_EN
    assign abort_w = ABORT;
`else
    assign abort_w = 1'b0;
`endif

    assign start_acc = START & ~start_q & (state_q == S_IDLE);
    assign run_last  = mode_q ? (idx_q == IDX_ZERO) : (idx_q == IDX_LAST);

    // start_q resets high so a START held through reset release is not an edge
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            start_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            start_q <= START;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        if (abort_w && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_acc) begin
                        state_d = S_LOAD;
                        mode_d  = MODE;
                        idx_d   = MODE ? IDX_LAST : IDX_ZERO;
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (run_last) begin
                        state_d = S_HOLD;
                    end else begin
                        idx_d = mode_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                    end
                end
                S_HOLD: begin
                    if (OUT_READY) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // DONE marks the handshake cycle itself, so it also looks at OUT_READY
    always_comb begin
        LOAD      = (state_q == S_LOAD);
        ROUND_EN  = (state_q == S_RUN);
        ROUND_IDX = idx_q;
        BUSY      = (state_q != S_IDLE);
        OUT_VALID = (state_q == S_HOLD);
        DONE      = (state_q == S_HOLD) & OUT_READY & ~abort_w;
    end
endmodule

// File: tb/tb_round_sequencer.sv
// Bench for round_sequencer: cycle-by-cycle model comparison plus hand-computed block-level expectations.
module tb_round_sequencer;
    localparam int R = 32;
    localparam int W = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic START = 1'b0;
    logic MODE = 1'b0;
    logic OUT_READY = 1'b0;
    logic abort_s;
`ifdef SEQ_ABORT_EN
    logic ABORT = 1'b0;
    assign abort_s = ABORT;
`else
    assign abort_s = 1'b0;
`endif

    logic         LOAD, ROUND_EN, BUSY, OUT_VALID, DONE;
    logic [W-1:0] ROUND_IDX;
    logic         s_load, s_en, s_busy, s_valid, s_done;
    logic [W-1:0] s_idx;

    round_sequencer #(.ROUNDS(R), .IDX_W(W)) u_dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .OUT_READY(OUT_READY),
`ifdef SEQ_ABORT_EN
        .ABORT(ABORT),
`endif
        .LOAD(LOAD), .ROUND_EN(ROUND_EN), .ROUND_IDX(ROUND_IDX), .BUSY(BUSY),
        .OUT_VALID(OUT_VALID), .DONE(DONE)
    );

    round_sequencer #(.ROUNDS(1), .IDX_W(W)) u_dut1 (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .OUT_READY(OUT_READY),
`ifdef SEQ_ABORT_EN
        .ABORT(ABORT),
`endif
        .LOAD(s_load), .ROUND_EN(s_en), .ROUND_IDX(s_idx), .BUSY(s_busy),
        .OUT_VALID(s_valid), .DONE(s_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Model: a block is described by its age in cycles since the accepting edge.
    // Age 1 = load cycle, ages 2..R+1 = the R rounds, age R+2 = holding the result.
    bit m_active = 1'b0;
    int m_age = 0;
    bit m_mode = 1'b0;
    bit m_prev_start = 1'b1;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_active = 1'b0;
            m_age = 0;
            m_prev_start = 1'b1;
        end else begin
            if (m_active) begin
                if (abort_s) m_active = 1'b0;
                else if (m_age == R + 2 && OUT_READY) m_active = 1'b0;
                else if (m_age < R + 2) m_age++;
            end else if (START && !m_prev_start) begin
                m_active = 1'b1;
                m_age = 1;
                m_mode = MODE;
            end
            m_prev_start = START;
        end
    end

    function automatic int exp_idx();
        if (!m_active) return 0;
        if (m_age == 1) return m_mode ? R - 1 : 0;
        if (m_age <= R + 1) return m_mode ? (R - 1) - (m_age - 2) : m_age - 2;
        return m_mode ? 0 : R - 1;
    endfunction

    int cnt_load = 0, cnt_en = 0, cnt_done = 0;
    int load_idx = 0, first_run_idx = 0, last_run_idx = 0, valid_rise_cyc = 0;
    bit prev_en = 1'b0, prev_valid = 1'b0;
    int s_cnt_en = 0, s_cnt_done = 0, s_bad_idx = 0, s_valid_rise_cyc = 0;
    bit s_prev_valid = 1'b0;

    always @(negedge CLK) begin
        check("load", 32'(LOAD), 32'(m_active && m_age == 1));
        check("round_en", 32'(ROUND_EN), 32'(m_active && m_age >= 2 && m_age <= R + 1));
        check("round_idx", 32'(ROUND_IDX), 32'(exp_idx()));
        check("busy", 32'(BUSY), 32'(m_active));
        check("out_valid", 32'(OUT_VALID), 32'(m_active && m_age == R + 2));
        check("done", 32'(DONE), 32'(m_active && m_age == R + 2 && OUT_READY && !abort_s));
        if (LOAD) begin cnt_load++; load_idx = 32'(ROUND_IDX); end
        if (ROUND_EN && !prev_en) first_run_idx = 32'(ROUND_IDX);
        if (ROUND_EN) begin cnt_en++; last_run_idx = 32'(ROUND_IDX); end
        prev_en = ROUND_EN;
        if (DONE) cnt_done++;
        if (OUT_VALID && !prev_valid) valid_rise_cyc = cyc;
        prev_valid = OUT_VALID;
        if (s_en) begin s_cnt_en++; if (s_idx != '0) s_bad_idx++; end
        if (s_done) s_cnt_done++;
        if (s_valid && !s_prev_valid) s_valid_rise_cyc = cyc;
        s_prev_valid = s_valid;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (!OUT_VALID && k < 60) begin step(1); k++; end
        check(name, 32'(OUT_VALID), 32'd1);
    endtask

    task automatic wait_round(input int idx, input string name);
        int k;
        k = 0;
        while (!(ROUND_EN && 32'(ROUND_IDX) == idx) && k < 60) begin step(1); k++; end
        check(name, 32'(ROUND_EN && 32'(ROUND_IDX) == idx), 32'd1);
    endtask

    initial begin
        int n0, c_load, c_en, c_done, c1_en, c1_done;
        step(3);
        check("reset_outputs", 32'({LOAD, ROUND_EN, ROUND_IDX, BUSY, OUT_VALID, DONE}), 32'd0);
        RST = 1'b0;
        step(2);

        // Encrypt, downstream always ready; the ROUNDS=1 instance runs alongside
        c_load = cnt_load; c_en = cnt_en; c_done = cnt_done; c1_en = s_cnt_en; c1_done = s_cnt_done;
        MODE = 1'b0; OUT_READY = 1'b1; START = 1'b1; n0 = cyc;
        wait_valid("enc_valid_timeout");
        step(1);
        check("enc_latency", 32'(valid_rise_cyc - n0), 32'd34);
        check("enc_load_cycles", 32'(cnt_load - c_load), 32'd1);
        check("enc_round_cycles", 32'(cnt_en - c_en), 32'd32);
        check("enc_first_idx", 32'(first_run_idx), 32'd0);
        check("enc_last_idx", 32'(last_run_idx), 32'd31);
        check("enc_done_pulses", 32'(cnt_done - c_done), 32'd1);
        check("enc_idle_after", 32'(BUSY), 32'd0);
        check("r1_round_cycles", 32'(s_cnt_en - c1_en), 32'd1);
        check("r1_idx_nonzero", 32'(s_bad_idx), 32'd0);
        check("r1_latency", 32'(s_valid_rise_cyc - n0), 32'd3);
        check("r1_done_pulses", 32'(s_cnt_done - c1_done), 32'd1);
        check("r1_idle_after", 32'(s_busy | s_load), 32'd0);
        START = 1'b0;
        step(2);

        // Decrypt; MODE flips right after acceptance and must be ignored
        c_en = cnt_en;
        MODE = 1'b1; START = 1'b1;
        step(1);
        MODE = 1'b0;
        wait_valid("dec_valid_timeout");
        step(1);
        check("dec_load_idx", 32'(load_idx), 32'd31);
        check("dec_first_idx", 32'(first_run_idx), 32'd31);
        check("dec_last_idx", 32'(last_run_idx), 32'd0);
        check("dec_round_cycles", 32'(cnt_en - c_en), 32'd32);
        START = 1'b0;
        step(2);

        // Downstream stalls 10 cycles in HOLD
        c_done = cnt_done;
        OUT_READY = 1'b0; START = 1'b1;
        wait_valid("stall_valid_timeout");
        START = 1'b0;
        step(10);
        check("stall_valid_held", 32'(OUT_VALID), 32'd1);
        check("stall_idx_frozen", 32'(ROUND_IDX), 32'd31);
        check("stall_no_done", 32'(cnt_done - c_done), 32'd0);
        OUT_READY = 1'b1;
        step(1);
        check("stall_done_pulse", 32'(cnt_done - c_done), 32'd1);
        check("stall_idle_after", 32'(BUSY), 32'd0);

        // START held across reset release, then edges during RUN
        c_load = cnt_load;
        START = 1'b1; RST = 1'b1;
        step(2);
        RST = 1'b0;
        step(5);
        check("held_start_no_block", 32'(cnt_load - c_load), 32'd0);
        START = 1'b0;
        step(1);
        c_en = cnt_en;
        START = 1'b1;
        step(6);
        START = 1'b0;
        step(1);
        START = 1'b1;
        step(1);
        START = 1'b0;
        wait_valid("edge_valid_timeout");
        step(4);
        check("edge_one_block", 32'(cnt_load - c_load), 32'd1);
        check("edge_round_cycles", 32'(cnt_en - c_en), 32'd32);

        // Reset mid-RUN at round 17
        c_done = cnt_done;
        START = 1'b1;
        wait_round(17, "rst_reach_round17");
        RST = 1'b1;
        #1;
        check("rst_async_outputs", 32'({LOAD, ROUND_EN, ROUND_IDX, BUSY, OUT_VALID, DONE}), 32'd0);
        step(1);
        RST = 1'b0; START = 1'b0;
        step(1);
        check("rst_no_done", 32'(cnt_done - c_done), 32'd0);
        c_en = cnt_en; c_done = cnt_done;
        START = 1'b1;
        wait_valid("rst_restart_valid_timeout");
        step(1);
        check("rst_restart_rounds", 32'(cnt_en - c_en), 32'd32);
        check("rst_restart_first_idx", 32'(first_run_idx), 32'd0);
        check("rst_restart_done", 32'(cnt_done - c_done), 32'd1);
        START = 1'b0;
        step(2);

`ifdef SEQ_ABORT_EN
        // ABORT at round 5 coincides with a fresh START edge
        c_load = cnt_load; c_done = cnt_done;
        START = 1'b1;
        step(1);
        START = 1'b0;
        wait_round(5, "abort_reach_round5");
        ABORT = 1'b1; START = 1'b1;
        step(1);
        ABORT = 1'b0;
        check("abort_idle", 32'(BUSY), 32'd0);
        check("abort_idx_zero", 32'(ROUND_IDX), 32'd0);
        step(3);
        check("abort_start_dropped", 32'(cnt_load - c_load), 32'd1);
        check("abort_no_done", 32'(cnt_done - c_done), 32'd0);
        START = 1'b0;
        step(2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
